data_memory_ctrl: RTL and testbench

Fixed-latency, line-granular main-memory model sitting directly downstream of the data cache. It consumes the cache's 256-bit memory request interface (enable/write/address/data) and returns a one-cycle acknowledge after a programmable latency, with read data for reads. It is the memory side of the cache-miss path: write-backs and line fills both pass through it. The design serialises requests, with one outstanding at a time.

---
 rtl/data_memory_ctrl_if.sv | 11 +
 rtl/data_memory_ctrl.sv | 50 +++++
 tb/tb_data_memory_ctrl.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/data_memory_ctrl_if.sv
// data_memory_ctrl_if: cache-to-memory line request bus, master = cache, slave = memory.
interface data_memory_ctrl_if #(parameter int LINE_BITS = 256);
  logic [31:0] addr_i;
  logic [LINE_BITS-1:0] data_i;
  logic enable_i;
  logic write_i;
  logic ack_o;
  logic [LINE_BITS-1:0] data_o;
  modport master(output addr_i, data_i, enable_i, write_i, input ack_o, data_o);
  modport slave(input addr_i, data_i, enable_i, write_i, output ack_o, data_o);
endinterface

// File: rtl/data_memory_ctrl.sv
// data_memory_ctrl: fixed-latency line-granular main memory, one request outstanding at a time.
module data_memory_ctrl #(
  parameter int LINE_BITS = 256,
  parameter int DEPTH = 512,
  parameter int LATENCY = 10
) (
  input logic clk_i,
  input logic rst_i,
  data_memory_ctrl_if.slave bus
);
  localparam int IW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;
  state_t state, nextState;
  logic [7:0] count;
  logic [IW-1:0] idx;
  logic [LINE_BITS-1:0] wrData, rdHold;
  logic isWrite;
  logic [LINE_BITS-1:0] mem [DEPTH];
  logic unusedAddrBits;
  assign unusedAddrBits = ^{bus.addr_i[4:0], bus.addr_i[31:5+IW]};
  always_comb begin
    nextState = state;
    nextState = state == IDLE ? (bus.enable_i ? (LATENCY == 1 ? ACK : WAIT) : IDLE) :
                state == WAIT ? (count <= 8'd1 ? ACK : WAIT) : IDLE;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      count <= 8'd0;
      idx <= '0;
      wrData <= '0;
      isWrite <= 1'b0;
      rdHold <= '0;
    end else begin
      state <= nextState;
      if (state == IDLE && bus.enable_i) begin
        count <= 8'(LATENCY - 1);
        idx <= bus.addr_i[5 +: IW];
        wrData <= bus.data_i;
        isWrite <= bus.write_i;
      end else if (state == WAIT) count <= count == 8'd0 ? 8'd0 : count - 8'd1;
      if (state == ACK && !isWrite) rdHold <= mem[idx];
    end
  end
  // Array is never reset; a reset landing on the ACK edge drops the pending write.
  always_ff @(posedge clk_i)
    if (!rst_i && state == ACK && isWrite) mem[idx] <= wrData;
  assign bus.ack_o = state == ACK;
  assign bus.data_o = (state == ACK && !isWrite) ? mem[idx] : rdHold;
endmodule

// File: tb/tb_data_memory_ctrl.sv
// tb_data_memory_ctrl: scoreboard bench for two instances, LATENCY=10 (A) and LATENCY=1 (B).
module tb_data_memory_ctrl;
  typedef struct {int cyc; logic [255:0] data;} exp_t;
  localparam logic [255:0] A5 = {32{8'hA5}};
  localparam logic [255:0] L1 = 256'h1111_0001;
  localparam logic [255:0] L2 = 256'h2222_0002;
  localparam logic [255:0] P5 = 256'h5555_0005;
  logic clk = 0, rst = 1;
  int cyc = 0, passCnt = 0, totalCnt = 0, c, t;
  exp_t qa[$], qb[$];
  exp_t ea, eb;
  logic [255:0] lastA, lastB;
  data_memory_ctrl_if #(.LINE_BITS(256)) busA();
  data_memory_ctrl_if #(.LINE_BITS(256)) busB();
  data_memory_ctrl #(.LINE_BITS(256), .DEPTH(512), .LATENCY(10)) dutA(.clk_i(clk), .rst_i(rst), .bus(busA.slave));
  data_memory_ctrl #(.LINE_BITS(256), .DEPTH(512), .LATENCY(1)) dutB(.clk_i(clk), .rst_i(rst), .bus(busB.slave));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    totalCnt++;
    if (act === exp) passCnt++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
  endtask
  always @(negedge clk) if (busA.ack_o) begin
    if (qa.size() == 0) begin
      totalCnt++;
      $display("FAIL a_unexpected_ack: got ack=1 expected ack=0 (cycle %0d)", cyc);
    end else begin
      ea = qa.pop_front();
      chk("a_ack_cycle", 256'(cyc), 256'(ea.cyc));
      chk("a_ack_data", busA.data_o, ea.data);
    end
  end
  always @(negedge clk) if (busB.ack_o) begin
    if (qb.size() == 0) begin
      totalCnt++;
      $display("FAIL b_unexpected_ack: got ack=1 expected ack=0 (cycle %0d)", cyc);
    end else begin
      eb = qb.pop_front();
      chk("b_ack_cycle", 256'(cyc), 256'(eb.cyc));
      chk("b_ack_data", busB.data_o, eb.data);
    end
  end
  task automatic waitAck(input bit b, output int ackCyc);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (b ? busB.ack_o : busA.ack_o) begin
        ackCyc = cyc;
        return;
      end
    end
    ackCyc = cyc;
    totalCnt++;
    $display("FAIL %s_ack_timeout: got no ack expected ack within 40 cycles", b ? "b" : "a");
  endtask
  task automatic setA(input logic e, input logic w, input logic [31:0] a, input logic [255:0] d);
    busA.enable_i = e;
    busA.write_i = w;
    busA.addr_i = a;
    busA.data_i = d;
  endtask
  task automatic setB(input logic e, input logic w, input logic [31:0] a, input logic [255:0] d);
    busB.enable_i = e;
    busB.write_i = w;
    busB.addr_i = a;
    busB.data_i = d;
  endtask
  initial begin
    setA(1, 0, 32'h60, '0);
    setB(0, 0, '0, '0);
    dutA.mem[3] = A5;
    dutA.mem[1] = L1;
    dutA.mem[2] = L2;
    dutA.mem[5] = P5;
    dutB.mem[0] = 256'h55;
    repeat (2) begin
      @(negedge clk);
      chk("rst_ack", 256'(busA.ack_o), 256'(0));
      chk("rst_data", busA.data_o, '0);
    end
    rst = 0;
    qa.push_back('{cyc + 10, A5});
    lastA = A5;
    waitAck(0, c);
    busA.enable_i = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("read_hold", busA.data_o, A5);
    end
    @(negedge clk);
    setA(1, 1, 32'h80, 256'h1234);
    qa.push_back('{cyc + 10, lastA});
    waitAck(0, c);
    setA(1, 0, 32'h9F, '0);
    qa.push_back('{c + 11, 256'h1234});
    lastA = 256'h1234;
    @(negedge clk);
    chk("ack_width", 256'(busA.ack_o), 256'(0));
    waitAck(0, c);
    busA.enable_i = 0;
    @(negedge clk);
    setA(1, 0, 32'h20, '0);
    qa.push_back('{cyc + 10, L1});
    lastA = L1;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      setA(k[0], 1, 32'h40, 256'hDEAD);
    end
    waitAck(0, c);
    busA.enable_i = 0;
    @(negedge clk);
    setA(1, 0, 32'h40, '0);
    qa.push_back('{cyc + 10, L2});
    lastA = L2;
    waitAck(0, c);
    busA.enable_i = 0;
    @(negedge clk);
    setA(1, 1, 32'hA0, 256'hFF);
    t = cyc;
    repeat (5) @(negedge clk);
    chk("rst_mid_cycle", 256'(cyc), 256'(t + 5));
    rst = 1;
    busA.enable_i = 0;
    @(negedge clk);
    rst = 0;
    chk("rst_abort_ack", 256'(busA.ack_o), 256'(0));
    chk("rst_abort_data", busA.data_o, '0);
    repeat (15) @(negedge clk);
    setA(1, 0, 32'hA0, '0);
    qa.push_back('{cyc + 10, P5});
    lastA = P5;
    waitAck(0, c);
    busA.enable_i = 0;
    lastB = '0;
    @(negedge clk);
    setB(1, 1, 32'h4000, 256'h7);
    qb.push_back('{cyc + 1, lastB});
    waitAck(1, c);
    setB(1, 0, 32'h0, '0);
    qb.push_back('{c + 2, 256'h7});
    lastB = 256'h7;
    waitAck(1, c);
    setB(1, 1, 32'h20, 256'h9);
    qb.push_back('{c + 2, lastB});
    waitAck(1, c);
    setB(1, 0, 32'h20, '0);
    qb.push_back('{c + 2, 256'h9});
    waitAck(1, c);
    busB.enable_i = 0;
    repeat (5) @(negedge clk);
    chk("a_queue_drained", 256'(qa.size()), 256'(0));
    chk("b_queue_drained", 256'(qb.size()), 256'(0));
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end
endmodule
